// File: rtl/bram_stream_reader_pkg.sv
// Shared definitions for the BRAM burst stream reader: FSM state encoding
// and output buffer depth.
package bram_stream_reader_pkg;

    localparam int READER_FIFO_DEPTH = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } reader_state_e;

endpackage : bram_stream_reader_pkg

// File: rtl/bram_stream_reader_fifo.sv
// Small synchronous FIFO with first-word-fall-through head and an occupancy count.
module sync_fifo
    import bram_stream_reader_pkg::*;
#(
    parameter  int DEPTH = READER_FIFO_DEPTH,
    parameter  int WIDTH = 8,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic [CNT_W-1:0] o_count,
    output logic             o_empty
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_full;
    logic             w_do_push;
    logic             w_do_pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
    endfunction

    assign o_empty   = (r_count == '0);
    assign w_full    = (r_count == CNT_W'(DEPTH));
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!w_full || w_do_pop);
    assign o_count   = r_count;

    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= next_ptr(r_wr_ptr);
            if (w_do_pop)  r_rd_ptr <= next_ptr(r_rd_ptr);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // NOTE: storage is deliberately left out of reset; the empty mask below keeps stale words invisible.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_wdata;
    end

    assign o_rdata = o_empty ? '0 : r_mem[r_rd_ptr];

endmodule : sync_fifo

// File: rtl/bram_stream_reader.sv
// Streams a burst of words from a 1-cycle-latency BRAM read port into a
// valid/ready output, issuing reads only when the output buffer has room.
module bram_stream_reader
    import bram_stream_reader_pkg::*;
#(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   length,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  busy,
    output logic                  done
);

    localparam int CNT_W = $clog2(READER_FIFO_DEPTH + 1);

    reader_state_e         r_state;
    reader_state_e         w_next_state;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [ADDR_WIDTH:0]   r_remaining;
    logic                  r_pending;
    logic                  r_zero_done;

    logic [CNT_W-1:0]      w_fifo_count;
    logic                  w_fifo_empty;
    logic [CNT_W:0]        w_inflight;
    logic                  w_accept;
    logic                  w_issue;
    logic                  w_pop;
    logic                  w_drained;

    // Credit: words buffered plus the read still in the BRAM pipe must leave a free slot.
    assign w_accept   = (r_state == IDLE) && start;
    assign w_inflight = {1'b0, w_fifo_count} + (CNT_W + 1)'(r_pending);
    assign w_issue    = (r_state == RUN) && (r_remaining != '0)
                        && (w_inflight < (CNT_W + 1)'(READER_FIFO_DEPTH));
    assign w_drained  = (r_state == DRAIN) && w_fifo_empty && !r_pending;
    assign w_pop      = !w_fifo_empty && out_ready;

    // NOTE: default assignment first so no path through always_comb infers a latch.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (start && (length != '0)) w_next_state = RUN;
            RUN:     if (w_issue && (r_remaining == (ADDR_WIDTH + 1)'(1))) w_next_state = DRAIN;
            DRAIN:   if (w_drained) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next_state;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr      <= '0;
            r_remaining <= '0;
            r_pending   <= 1'b0;
            r_zero_done <= 1'b0;
        end else begin
            r_pending   <= w_issue;
            r_zero_done <= w_accept && (length == '0);
            if (w_accept && (length != '0)) begin
                r_addr      <= base_addr;
                r_remaining <= length;
            end else if (w_issue) begin
                r_addr      <= r_addr + ADDR_WIDTH'(1);
                r_remaining <= r_remaining - (ADDR_WIDTH + 1)'(1);
            end
        end
    end

    // The BRAM word for a read issued last cycle is present on rd_data now.
    sync_fifo #(
        .DEPTH (READER_FIFO_DEPTH),
        .WIDTH (DATA_WIDTH)
    ) u_out_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (r_pending),
        .i_wdata (rd_data),
        .i_pop   (w_pop),
        .o_rdata (out_data),
        .o_count (w_fifo_count),
        .o_empty (w_fifo_empty)
    );

    assign rd_addr   = r_addr;
    assign out_valid = !w_fifo_empty;
    assign busy      = (r_state != IDLE);
    assign done      = r_zero_done || w_drained;

endmodule : bram_stream_reader
